// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1024x768@60 raster timing generator.
// Issues pixel coordinates PIX_LEAD cycles before the active window so that the
// pixel_data returned by the display block lines up with vga_de. The RGB565
// output is gated to zero during blanking.
// Optional build macro VGA_TEST_PATTERN_EN: replaces pixel_data with eight
// 128-pixel-wide vertical colour bars while the request outputs keep running.
module vga_timing_gen #(
  parameter int   H_SYNC   = 136,
  parameter int   H_BACK   = 160,
  parameter int   H_DISP   = 1024,
  parameter int   H_FRONT  = 24,
  parameter int   V_SYNC   = 6,
  parameter int   V_BACK   = 29,
  parameter int   V_DISP   = 768,
  parameter int   V_FRONT  = 3,
  parameter int   PIX_LEAD = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;

  // Sized copies of the timing points so every compare is width-matched.
  localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_C  = 11'(H_ACT);
  localparam logic [10:0] H_END_C  = 11'(H_ACT + H_DISP);
  localparam logic [10:0] X_OFS_C  = 11'(H_ACT - PIX_LEAD);
  localparam logic [11:0] H_ACT_L  = 12'(H_ACT);
  localparam logic [11:0] H_END_L  = 12'(H_ACT + H_DISP);
  localparam logic [11:0] LEAD_L   = 12'(PIX_LEAD);
  localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_C  = 10'(V_ACT);
  localparam logic [9:0]  V_END_C  = 10'(V_ACT + V_DISP);

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_h_sync;
  logic        w_v_sync;
  logic        w_h_act;
  logic        w_v_act;
  logic [11:0] w_h_lead;
  logic        w_h_req;
  logic        w_req;
  logic        w_de;

  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_req;
  logic        r_fs;
  logic [10:0] r_xpos;
  logic [10:0] r_ypos;

  // Timing decode of the current counter position.
  assign w_h_wrap = (r_h_cnt == H_LAST_C);
  assign w_v_wrap = (r_v_cnt == V_LAST_C);
  assign w_h_sync = (r_h_cnt < H_SYNC_C);
  assign w_v_sync = (r_v_cnt < V_SYNC_C);
  assign w_h_act  = (r_h_cnt >= H_ACT_C) && (r_h_cnt < H_END_C);
  assign w_v_act  = (r_v_cnt >= V_ACT_C) && (r_v_cnt < V_END_C);
  // The lead is added in 12 bits so the request window can never wrap past
  // the end of the line into the next one.
  assign w_h_lead = {1'b0, r_h_cnt} + LEAD_L;
  assign w_h_req  = (w_h_lead >= H_ACT_L) && (w_h_lead < H_END_L);
  assign w_req    = w_h_req && w_v_act;
  assign w_de     = w_h_act && w_v_act;

  // Horizontal and vertical raster counters; v advances on the h wrap only.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!sys_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // Registered sync, enable, request and frame-start outputs (one cycle
  // behind the counters, so all of them share the same alignment).
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_de   <= 1'b0;
      r_req  <= 1'b0;
      r_fs   <= 1'b0;
      r_xpos <= '0;
      r_ypos <= '0;
    end else begin
      r_hs   <= w_h_sync ? SYNC_POL : ~SYNC_POL;
      r_vs   <= w_v_sync ? SYNC_POL : ~SYNC_POL;
      r_de   <= w_de;
      r_req  <= w_req;
      r_fs   <= (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);
      r_xpos <= w_req ? (r_h_cnt - X_OFS_C) : 11'd0;
      r_ypos <= w_req ? {1'b0, r_v_cnt - V_ACT_C} : 11'd0;
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_de      = r_de;
  assign data_req    = r_req;
  assign frame_start = r_fs;
  assign pixel_xpos  = r_xpos;
  assign pixel_ypos  = r_ypos;

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]  r_col;
  logic [15:0] w_bar;

  // Active-column counter: 0 on the first vga_de cycle of each line.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col <= '0;
    end else if (w_de && r_de) begin
      r_col <= r_col + 10'd1;
    end else begin
      r_col <= '0;
    end
  end

  // Colour-bar lookup, 128 columns per bar.
  always_comb begin
    w_bar = 16'h0000;
    case (r_col[9:7])
      3'd0:    w_bar = 16'hFFFF;
      3'd1:    w_bar = 16'hFFE0;
      3'd2:    w_bar = 16'h07FF;
      3'd3:    w_bar = 16'h07E0;
      3'd4:    w_bar = 16'hF81F;
      3'd5:    w_bar = 16'hF800;
      3'd6:    w_bar = 16'h001F;
      default: w_bar = 16'h0000;
    endcase
  end

  assign vga_rgb = r_de ? w_bar : 16'h0000;
`else
  assign vga_rgb = r_de ? pixel_data : 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen.
// Instance a: default 1024x768 timing, checked up to the first active line.
// Instance b: a small raster (28x9, lead 3, active-high sync) checked over
// whole frames, including a mid-line asynchronous reset.
module tb_vga_timing_gen;

  // Small raster: H 4+5+16+3 = 28, V 2+2+4+1 = 9, frame = 252 cycles.
  localparam int S_FRAME = 252;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk;
  logic        rst_a;
  logic        rst_b;
  logic        b_const;
  logic [15:0] pd_a;
  logic [15:0] pd_b;

  logic [10:0] a_xpos, a_ypos, b_xpos, b_ypos;
  logic        a_req, a_hs, a_vs, a_de, a_fs;
  logic        b_req, b_hs, b_vs, b_de, b_fs;
  logic [15:0] a_rgb, b_rgb;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] pipe_b [3];

  vga_timing_gen dut_a (
    .vga_clk     (clk),
    .sys_rst_n   (rst_a),
    .pixel_data  (pd_a),
    .pixel_xpos  (a_xpos),
    .pixel_ypos  (a_ypos),
    .data_req    (a_req),
    .vga_hs      (a_hs),
    .vga_vs      (a_vs),
    .vga_de      (a_de),
    .vga_rgb     (a_rgb),
    .frame_start (a_fs)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(5), .H_DISP(16), .H_FRONT(3),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4),  .V_FRONT(1),
    .PIX_LEAD(3), .SYNC_POL(1'b1)
  ) dut_b (
    .vga_clk     (clk),
    .sys_rst_n   (rst_b),
    .pixel_data  (pd_b),
    .pixel_xpos  (b_xpos),
    .pixel_ypos  (b_ypos),
    .data_req    (b_req),
    .vga_hs      (b_hs),
    .vga_vs      (b_vs),
    .vga_de      (b_de),
    .vga_rgb     (b_rgb),
    .frame_start (b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display-block model for instance b: three-stage pipeline returning the
  // requested coordinates encoded as {x[4:0], y[5:0], x[4:0]}.
  always @(posedge clk) begin
    pipe_b[0] <= {b_xpos[4:0], b_ypos[5:0], b_xpos[4:0]};
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign pd_b = b_const ? 16'hFFFF : pipe_b[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_b_reset(input string tag);
    check({tag, "_hs"},   b_hs,   0);
    check({tag, "_vs"},   b_vs,   0);
    check({tag, "_de"},   b_de,   0);
    check({tag, "_req"},  b_req,  0);
    check({tag, "_fs"},   b_fs,   0);
    check({tag, "_xpos"}, b_xpos, 0);
    check({tag, "_ypos"}, b_ypos, 0);
    check({tag, "_rgb"},  b_rgb,  0);
  endtask

  // Measure one full frame of instance b starting at its frame_start sample.
  task automatic measure_frame_b(input string tag, input logic cmode);
    int fs_n = 0, hs_n = 0, vs_n = 0, de_n = 0, rq_n = 0, rise_n = 0;
    int lead_err = 0, rgb_err = 0, col = 0, row = -1, guard = 0;
    logic prev_rq = 1'b0, prev_de = 1'b0;
    logic [2:0] rq_hist = '0;
    logic [15:0] exp_rgb;
    while (b_fs !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (b_fs !== 1'b1) begin
      check({tag, "_fs_found"}, b_fs, 1);
      return;
    end
    check({tag, "_hs_at_fs"}, b_hs, 1);
    check({tag, "_vs_at_fs"}, b_vs, 1);
    for (int t = 0; t < S_FRAME; t++) begin
      fs_n += int'(b_fs);
      hs_n += int'(b_hs);
      vs_n += int'(b_vs);
      de_n += int'(b_de);
      rq_n += int'(b_req);
      if (b_req && !prev_rq) rise_n++;
      if (b_de !== rq_hist[2]) lead_err++;
      rq_hist = {rq_hist[1:0], b_req};
      if (b_de) begin
        if (!prev_de) begin
          row++;
          col = 0;
        end else begin
          col++;
        end
        exp_rgb = (cmode || TP) ? 16'hFFFF : {5'(col), 6'(row), 5'(col)};
      end else begin
        exp_rgb = 16'h0000;
      end
      if (b_rgb !== exp_rgb) rgb_err++;
      prev_rq = b_req;
      prev_de = b_de;
      @(negedge clk);
    end
    check({tag, "_fs_count"},  fs_n,     1);
    check({tag, "_hs_active"}, hs_n,     36);
    check({tag, "_vs_active"}, vs_n,     56);
    check({tag, "_de_count"},  de_n,     64);
    check({tag, "_req_count"}, rq_n,     64);
    check({tag, "_req_rises"}, rise_n,   4);
    check({tag, "_lead_err"},  lead_err, 0);
    check({tag, "_rgb_err"},   rgb_err,  0);
    check({tag, "_rows"},      row,      3);
    check({tag, "_next_fs"},   b_fs,     1);
  endtask

  initial begin
    int guard;
    int hs_low, vs_low, de_early, fs_extra;
    int first_req, first_de, last_req, last_x, de_fall;
    logic [15:0] first_rx, first_ry;
    logic seen_de;
    logic [15:0] exp_c0, exp_c127, exp_c128, exp_c1023;

    rst_a   = 1'b0;
    rst_b   = 1'b0;
    b_const = 1'b0;
    pd_a    = 16'hA5A5;
    repeat (3) @(negedge clk);

    // Reset values of both instances.
    check("a_rst_hs",   a_hs,   1);
    check("a_rst_vs",   a_vs,   1);
    check("a_rst_de",   a_de,   0);
    check("a_rst_req",  a_req,  0);
    check("a_rst_fs",   a_fs,   0);
    check("a_rst_rgb",  a_rgb,  0);
    check("a_rst_xpos", a_xpos, 0);
    check_b_reset("b_rst");

    // Instance b: release, two frames (display model, then constant white).
    rst_b = 1'b1;
    @(negedge clk);
    check("b_fs_first", b_fs, 1);
    measure_frame_b("b_f1", 1'b0);
    b_const = 1'b1;
    measure_frame_b("b_f2", 1'b1);
    b_const = 1'b0;

    // Mid-line asynchronous reset while vga_de is high.
    guard = 0;
    while (b_de !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("b_de_seen", b_de, 1);
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b0;
    #1 check_b_reset("b_async");
    repeat (3) @(negedge clk);
    check_b_reset("b_hold");
    rst_b = 1'b1;
    @(negedge clk);
    check("b_fs_after_rst", b_fs, 1);
    measure_frame_b("b_f3", 1'b0);

    // Instance a: default timing up to the end of line 35.
`ifdef VGA_TEST_PATTERN_EN
    exp_c0 = 16'hFFFF; exp_c127 = 16'hFFFF; exp_c128 = 16'hFFE0; exp_c1023 = 16'h0000;
`else
    exp_c0 = 16'hA5A5; exp_c127 = 16'hA5A5; exp_c128 = 16'hA5A5; exp_c1023 = 16'hA5A5;
`endif
    rst_a = 1'b1;
    @(negedge clk);
    check("a_fs_first", a_fs, 1);
    check("a_hs_at_fs", a_hs, 0);
    check("a_vs_at_fs", a_vs, 0);
    hs_low = 0; vs_low = 0; de_early = 0; fs_extra = 0;
    first_req = -1; first_de = -1; last_req = -1; last_x = -1; de_fall = -1;
    first_rx = '1; first_ry = '1;
    seen_de = 1'b0;
    for (int t = 0; t <= 48362; t++) begin
      if (t < 1344 && a_hs == 1'b0) hs_low++;
      if (a_vs == 1'b0) vs_low++;
      if (t < 47040 && a_de) de_early++;
      if (t > 0 && a_fs) fs_extra++;
      if (a_req) begin
        if (first_req < 0) begin
          first_req = t;
          first_rx  = 16'(a_xpos);
          first_ry  = 16'(a_ypos);
        end
        last_req = t;
        last_x   = int'(a_xpos);
      end
      if (a_de && first_de < 0) first_de = t;
      if (a_de) seen_de = 1'b1;
      if (seen_de && !a_de && de_fall < 0) de_fall = t;
      if (t == 47335)        check("a_rgb_pre_de", a_rgb, 0);
      if (t == 47336)        check("a_rgb_col0",    a_rgb, exp_c0);
      if (t == 47336 + 127)  check("a_rgb_col127",  a_rgb, exp_c127);
      if (t == 47336 + 128)  check("a_rgb_col128",  a_rgb, exp_c128);
      if (t == 47336 + 1023) check("a_rgb_col1023", a_rgb, exp_c1023);
      @(negedge clk);
    end
    check("a_hs_low_line0", hs_low,    136);
    check("a_vs_low",       vs_low,    8064);
    check("a_de_early",     de_early,  0);
    check("a_fs_extra",     fs_extra,  0);
    check("a_first_req_t",  first_req, 47334);
    check("a_first_req_x",  first_rx,  0);
    check("a_first_req_y",  first_ry,  0);
    check("a_first_de_t",   first_de,  47336);
    check("a_last_req_t",   last_req,  48357);
    check("a_last_req_x",   last_x,    1023);
    check("a_de_fall_t",    de_fall,   48360);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 1024x768@60 VGA raster timing on vga_clk and drives the display block's pixel_xpos/pixel_ypos pixel request.
Issues coordinates PIX_LEAD cycles ahead of the active video window, so the pixel_data that returns after the display block's register and ROM latency lines up with vga_de.
Gates the returned pixel_data onto the RGB565 output bus and drives hsync/vsync/de to the HDMI/VGA encoder.

Parameters:
H_SYNC, 136, horizontal sync width (clocks)
H_BACK, 160, horizontal back porch
H_DISP, 1024, horizontal active pixels
H_FRONT, 24, horizontal front porch
V_SYNC, 6, vertical sync width (lines)
V_BACK, 29, vertical back porch
V_DISP, 768, vertical active lines
V_FRONT, 3, vertical front porch
PIX_LEAD, 2, cycles between coordinate issue and pixel_data return; legal range 1..H_SYNC+H_BACK-1
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
vga_clk  in  1  pixel clock
sys_rst_n  in  1  reset; asynchronous, active-low
pixel_data  in  16  RGB565 returned by the display block
pixel_xpos  out  11  requested column, 0..H_DISP-1
pixel_ypos  out  11  requested row, 0..V_DISP-1
data_req  out  1  pixel_xpos/pixel_ypos are valid
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  active video
vga_rgb  out  16  RGB565 to the encoder
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Derived values:
  - H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT = 1344.
  - V_TOTAL = 806.
  - H_ACT = H_SYNC+H_BACK.
  - V_ACT = V_SYNC+V_BACK.
- h_cnt (11b):
  - counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt (10b):
  - increments only on the h_cnt wrap cycle.
  - wraps 0 after V_TOTAL-1; the simultaneous h and v wrap goes to (0,0).
- Line and frame order are sync, back porch, active, front porch.
- All outputs except vga_rgb are registered; they are a function of the counter values from the previous cycle.
- Output functions (counter value c = previous cycle's h_cnt/v_cnt):
  - vga_hs = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
  - vga_vs = SYNC_POL when v_cnt < V_SYNC, else ~SYNC_POL.
  - vga_de = 1 iff H_ACT <= h_cnt < H_ACT+H_DISP and V_ACT <= v_cnt < V_ACT+V_DISP.
  - data_req = 1 iff H_ACT <= h_cnt+PIX_LEAD < H_ACT+H_DISP and v_cnt is in the active range. The request window therefore never crosses a line boundary.
  - pixel_xpos = h_cnt+PIX_LEAD-H_ACT when data_req, else 0.
  - pixel_ypos = v_cnt-V_ACT when data_req, else 0.
  - frame_start = 1 for exactly one cycle following the cycle with h_cnt==0 and v_cnt==0.
- Pixel request timing:
  - Coordinate N is issued exactly PIX_LEAD cycles before the vga_de cycle for column N.
  - Per line: data_req rises PIX_LEAD cycles before vga_de rises and falls PIX_LEAD cycles before vga_de falls.
- vga_rgb = vga_de ? pixel_data : 16'h0000 (combinational mux). It is forced to 0 during blanking.
- Reset:
  - counters = 0, vga_de = 0, data_req = 0, pixel_xpos = 0, pixel_ypos = 0, frame_start = 0, vga_rgb = 0.
  - vga_hs and vga_vs = ~SYNC_POL (inactive).
  - On release, counting starts at (0,0) and the first frame_start occurs in the first cycle after release.
  - Reset mid-frame discards the current frame; there is no partial-line recovery.
- Per-frame counts: exactly H_DISP*V_DISP de cycles and exactly V_DISP rising edges of data_req.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined:
  - vga_rgb ignores pixel_data.
  - During vga_de it outputs 8 vertical colour bars, each 128 px wide: WHITE, YELLOW 16'hFFE0, CYAN 16'h07FF, GREEN 16'h07E0, MAGENTA 16'hF81F, RED 16'hF800, BLUE 16'h001F, BLACK.
  - The bar is selected by an internal active-column counter bits [9:7].
  - data_req and the coordinate outputs keep toggling unchanged.
- Undefined: vga_rgb behaves as specified above, and the bar logic and column counter are not synthesised.

Test Plan:
1. Reset release, run 2 frames -> frame_start period = 1344*806 = 1083264 cycles; hs low 136 cycles per 1344; vs low 6 lines per 806; 786432 de cycles per frame.
2. Line 35 (first active line) -> data_req rises 2 cycles before vga_de with pixel_xpos=0, pixel_ypos=0; last request pixel_xpos=1023 occurs 2 cycles before vga_de falls.
3. Model display as 2-stage pipeline returning {xpos[4:0],ypos[5:0],xpos[4:0]} -> every vga_de cycle vga_rgb decodes to the column/row that vga_de represents; zero mismatches over a full frame.
4. Drive pixel_data=16'hFFFF constantly -> vga_rgb=0 for all blanking cycles, 16'hFFFF only while vga_de=1.
5. Assert sys_rst_n low mid-line (h_cnt=600, v_cnt=400) for 3 cycles -> all outputs take their reset values asynchronously; after release, frame_start fires next cycle and the timing of test 1 repeats.
6. With VGA_TEST_PATTERN_EN, active column 0/127/128/1023 -> 16'hFFFF/16'hFFFF/16'hFFE0/16'h0000.
